// File: rtl/frame_buffer_pingpong.sv
// Double-buffered frame store: serial colour components are packed into pixels in
// the write bank while a scanout reader sees a stable, complete frame in the other bank.
module frame_buffer_pingpong #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned PIXELS   = 10,
    parameter int unsigned LINES    = 10,
    parameter int unsigned PX_W     = 4,
    parameter int unsigned LINE_W   = 4
) (
    input  logic                         Clock,
    input  logic                         Reset_n,
    input  logic                         WrValid,
    output logic                         WrReady,
    input  logic [DATA_W-1:0]            WrData,
    input  logic                         RdEn,
    input  logic [LINE_W-1:0]            RdLine,
    input  logic [PX_W-1:0]              RdPx,
    output logic [DATA_W*CHANNELS-1:0]   RdData,
    output logic                         RdValid,
    output logic                         FrameReady,
    input  logic                         FrameRelease,
    output logic [7:0]                   FrameCount
);

    localparam int unsigned PIX_BITS   = DATA_W * CHANNELS;
    localparam int unsigned CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned BANK_DEPTH = LINES * PIXELS;
    localparam int unsigned DEPTH      = 2 * BANK_DEPTH;
    localparam int unsigned ADDR_W     = $clog2(DEPTH);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                swap;
    logic                wr_bank;
    logic                rd_bank;
    logic [CH_W-1:0]     chan;
    logic [PX_W-1:0]     px;
    logic [LINE_W-1:0]   line;
    logic [PIX_BITS-1:0] stage;
    logic [PIX_BITS-1:0] pix_c;
    logic                xfer;
    logic                last_chan;
    logic                last_px;
    logic                last_line;
    logic                frame_done;
    logic                rd_in_range;
    logic [ADDR_W-1:0]   wr_addr;
    logic [ADDR_W-1:0]   rd_addr;
    logic                wr_ready;
    logic                frame_ready;
    logic [7:0]          frame_count;
    logic                rd_valid;
    logic [PIX_BITS-1:0] rd_data;

    logic [PIX_BITS-1:0] mem [DEPTH];

    assign WrReady    = wr_ready;
    assign FrameReady = frame_ready;
    assign FrameCount = frame_count;
    assign RdValid    = rd_valid;
    assign RdData     = rd_data;

    // Handshake and write-position decode
    assign xfer       = WrValid && (state == ST_FILL);
    assign last_chan  = (chan == CH_W'(CHANNELS - 1));
    assign last_px    = (px == PX_W'(PIXELS - 1));
    assign last_line  = (line == LINE_W'(LINES - 1));
    assign frame_done = xfer && last_chan && last_px && last_line;
    assign rd_bank    = ~wr_bank;

    assign wr_addr = ADDR_W'(BANK_DEPTH * 32'(wr_bank) + PIXELS * 32'(line) + 32'(px));
    assign rd_addr = ADDR_W'(BANK_DEPTH * 32'(rd_bank) + PIXELS * 32'(RdLine) + 32'(RdPx));
    assign rd_in_range = (32'(RdLine) < LINES) && (32'(RdPx) < PIXELS);

    // Final component completes the staged pixel in the same cycle it arrives
    always_comb begin
        pix_c = stage;
        pix_c[(CHANNELS - 1) * DATA_W +: DATA_W] = WrData;
    end

    // Next-state: swap immediately if the reader is free or releasing, else wait in HOLD
    always_comb begin
        state_nxt = state;
        swap      = 1'b0;
        case (state)
            ST_FILL: begin
                if (frame_done) begin
                    if (!frame_ready || FrameRelease) begin
                        swap = 1'b1;
                    end else begin
                        state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (FrameRelease) begin
                    swap      = 1'b1;
                    state_nxt = ST_FILL;
                end
            end
            default: state_nxt = ST_FILL;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= ST_FILL;
            wr_ready    <= 1'b1;
            wr_bank     <= 1'b0;
            frame_ready <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            state    <= state_nxt;
            wr_ready <= (state_nxt == ST_FILL);
            if (swap) begin
                wr_bank     <= ~wr_bank;
                frame_ready <= 1'b1;
                frame_count <= frame_count + 8'd1;
            end else if (FrameRelease && frame_ready) begin
                frame_ready <= 1'b0;
            end
        end
    end

    // Channel -> pixel -> line auto-indexing
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            chan  <= '0;
            px    <= '0;
            line  <= '0;
            stage <= '0;
        end else if (swap) begin
            chan <= '0;
            px   <= '0;
            line <= '0;
        end else if (xfer) begin
            stage[32'(chan) * DATA_W +: DATA_W] <= WrData;
            if (!last_chan) begin
                chan <= chan + CH_W'(1);
            end else begin
                chan <= '0;
                if (!last_px) begin
                    px <= px + PX_W'(1);
                end else begin
                    px <= '0;
                    line <= last_line ? '0 : line + LINE_W'(1);
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (xfer && last_chan) begin
            mem[wr_addr] <= pix_c;
        end
    end

    // Read port: one-cycle latency, reads the pre-swap bank on a swap edge
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (RdEn && frame_ready) begin
            rd_valid <= 1'b1;
            rd_data  <= rd_in_range ? mem[rd_addr] : '0;
        end else begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_frame_buffer_pingpong.sv
// Directed-plus-random bench for frame_buffer_pingpong, checked against a
// frame-level model (whole frames as pixel arrays, counted in transfers).
module tb_frame_buffer_pingpong;

    localparam int DATA_W   = 8;
    localparam int CHANNELS = 3;
    localparam int PIXELS   = 10;
    localparam int LINES    = 10;
    localparam int NPIX     = PIXELS * LINES;
    localparam int TOTAL    = NPIX * CHANNELS;

    logic        Clock;
    logic        Reset_n;
    logic        WrValid;
    logic        WrReady;
    logic [7:0]  WrData;
    logic        RdEn;
    logic [3:0]  RdLine;
    logic [3:0]  RdPx;
    logic [23:0] RdData;
    logic        RdValid;
    logic        FrameReady;
    logic        FrameRelease;
    logic [7:0]  FrameCount;

    int total = 0;
    int bad   = 0;

    // Model: frame being assembled, frame visible to the reader, status
    logic [23:0] m_cur   [NPIX];
    logic [23:0] m_rbank [NPIX];
    int          m_idx;
    bit          m_hold;
    bit          m_fr;
    int          m_cnt;
    bit          exp_rdv;
    logic [23:0] exp_rdd;

    frame_buffer_pingpong dut (
        .Clock(Clock), .Reset_n(Reset_n), .WrValid(WrValid), .WrReady(WrReady),
        .WrData(WrData), .RdEn(RdEn), .RdLine(RdLine), .RdPx(RdPx),
        .RdData(RdData), .RdValid(RdValid), .FrameReady(FrameReady),
        .FrameRelease(FrameRelease), .FrameCount(FrameCount)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_idx   = 0;
        m_hold  = 0;
        m_fr    = 0;
        m_cnt   = 0;
        exp_rdv = 0;
        exp_rdd = '0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".wr_ready"},    32'(WrReady),    32'(!m_hold));
        chk({tag, ".frame_ready"}, 32'(FrameReady), 32'(m_fr));
        chk({tag, ".frame_count"}, 32'(FrameCount), 32'(m_cnt));
        chk({tag, ".rd_valid"},    32'(RdValid),    32'(exp_rdv));
        chk({tag, ".rd_data"},     32'(RdData),     32'(exp_rdd));
    endtask

    // One clock: drive inputs, advance the model over the edge, check after it
    task automatic step(input string tag, input logic v, input logic [7:0] d, input logic rel,
                        input logic re, input logic [3:0] rl, input logic [3:0] rp);
        bit done;
        bit swp;
        WrValid = v; WrData = d; FrameRelease = rel; RdEn = re; RdLine = rl; RdPx = rp;
        @(posedge Clock);
        if (re && m_fr) begin
            exp_rdv = 1;
            exp_rdd = (int'(rl) < LINES && int'(rp) < PIXELS) ? m_rbank[int'(rl) * PIXELS + int'(rp)] : 24'h0;
        end else begin
            exp_rdv = 0;
        end
        done = 0;
        if (v && !m_hold) begin
            m_cur[m_idx / CHANNELS][(m_idx % CHANNELS) * DATA_W +: DATA_W] = d;
            m_idx++;
            if (m_idx == TOTAL) begin
                done  = 1;
                m_idx = 0;
            end
        end
        swp = 0;
        if (m_hold) swp = rel;
        else if (done) begin
            if (!m_fr || rel) swp = 1;
            else m_hold = 1;
        end
        if (swp) begin
            m_rbank = m_cur;
            m_fr    = 1;
            m_cnt   = (m_cnt + 1) % 256;
            m_hold  = 0;
        end else if (rel && m_fr) begin
            m_fr = 0;
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 4'd0);
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < NPIX; i++)
            step(tag, 1'b0, 8'h00, 1'b0, 1'b1, 4'(i / PIXELS), 4'(i % PIXELS));
    endtask

    initial begin
        Reset_n = 1'b0; WrValid = 0; WrData = 0; FrameRelease = 0; RdEn = 0; RdLine = 0; RdPx = 0;
        model_reset();
        repeat (2) @(posedge Clock);
        #1;
        check_outputs("reset");
        @(negedge Clock);
        Reset_n = 1'b1;
        idle("post_reset");

        // Frame A: n mod 256, one per cycle
        for (int n = 0; n < TOTAL; n++) step("frame_a", 1'b1, 8'(n % 256), 1'b0, 1'b0, 4'd0, 4'd0);
        chk("frame_a.frame_ready", 32'(FrameReady), 32'd1);
        chk("frame_a.frame_count", 32'(FrameCount), 32'd1);
        step("rd00", 1'b0, 8'h00, 1'b0, 1'b1, 4'd0, 4'd0);
        chk("rd00.const", 32'(RdData), 32'h020100);
        step("rd99", 1'b0, 8'h00, 1'b0, 1'b1, 4'd9, 4'd9);
        chk("rd99.const", 32'(RdData), 32'h2B2A29);

        // Frame B: same pattern with WrValid gaps and junk data on idle cycles
        step("release_a", 1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 4'd0);
        for (int n = 0; n < TOTAL; ) begin
            step("frame_b_gap", 1'b0, 8'($urandom), 1'b0, 1'b0, 4'd0, 4'd0);
            step("frame_b", 1'b1, 8'(n % 256), 1'b0, 1'b0, 4'd0, 4'd0);
            n++;
        end
        read_all("read_b");
        step("rd99_b", 1'b0, 8'h00, 1'b0, 1'b1, 4'd9, 4'd9);
        chk("rd99_b.const", 32'(RdData), 32'h2B2A29);

        // Frame C: random data with background reads, no release -> HOLD
        for (int n = 0; n < TOTAL; n++)
            step("frame_c", 1'b1, 8'($urandom), 1'b0, 1'($urandom), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)));
        chk("hold.wr_ready", 32'(WrReady), 32'd0);
        for (int i = 0; i < 5; i++) step("hold", 1'b1, 8'($urandom), 1'b0, 1'b0, 4'd0, 4'd0);
        step("hold_release", 1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 4'd0);
        chk("hold_release.frame_ready", 32'(FrameReady), 32'd1);
        chk("hold_release.wr_ready", 32'(WrReady), 32'd1);
        read_all("read_c");

        // Frame D: release coincides with the frame-complete transfer
        for (int n = 0; n < TOTAL; n++)
            step("frame_d", 1'b1, 8'($urandom), 1'(n == TOTAL - 1), 1'($urandom), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)));
        chk("sim_release.wr_ready", 32'(WrReady), 32'd1);
        chk("sim_release.frame_ready", 32'(FrameReady), 32'd1);
        read_all("read_d");

        step("oor", 1'b0, 8'h00, 1'b0, 1'b1, 4'd10, 4'd3);
        chk("oor.rd_data", 32'(RdData), 32'd0);
        chk("oor.rd_valid", 32'(RdValid), 32'd1);
        for (int i = 0; i < 40; i++)
            step("b2b", 1'b0, 8'h00, 1'b0, 1'b1, 4'($urandom), 4'($urandom));
        step("rd_last", 1'b0, 8'h00, 1'b0, 1'b1, 4'd4, 4'd7);
        step("release_d", 1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 4'd0);
        for (int i = 0; i < 3; i++) step("rd_not_ready", 1'b0, 8'h00, 1'b0, 1'b1, 4'd1, 4'd1);

        // Mid-frame asynchronous reset
        for (int n = 0; n < 150; n++) step("partial", 1'b1, 8'($urandom), 1'b0, 1'b0, 4'd0, 4'd0);
        step("pre_reset_ready", 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 4'd0);
        Reset_n = 1'b0;
        WrValid = 0; FrameRelease = 0; RdEn = 0;
        model_reset();
        #1;
        check_outputs("async_reset");
        @(negedge Clock);
        Reset_n = 1'b1;
        for (int n = 0; n < TOTAL; n++) step("frame_e", 1'b1, 8'(n % 256), 1'b0, 1'b0, 4'd0, 4'd0);
        chk("frame_e.frame_count", 32'(FrameCount), 32'd1);
        read_all("read_e");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
